// File: rtl/pu_tag_pkg.sv
// Shared types and constants for the tag lookup result collector.
`ifndef PU_ID_NBITS
`define PU_ID_NBITS 2
`endif
`ifndef RCI_NBITS
`define RCI_NBITS 8
`endif

package pu_tag_pkg;

  localparam int unsigned TAG_PID_NBITS   = `PU_ID_NBITS;
  localparam int unsigned TAG_RCI_NBITS   = `RCI_NBITS;
  localparam int unsigned TAG_CNT_NBITS   = 4;
  localparam int unsigned TAG_MAX_RESULTS = 8;

  typedef struct packed {
    logic [TAG_PID_NBITS-1:0] pid;
    logic [TAG_CNT_NBITS-1:0] count;
  } tag_done_entry_t;

  // Lookup status can report more than a slot can hold; saturate at slot capacity.
  function automatic logic [TAG_CNT_NBITS-1:0] clamp_status(input logic [TAG_CNT_NBITS-1:0] st);
    return (st > TAG_CNT_NBITS'(TAG_MAX_RESULTS)) ? TAG_CNT_NBITS'(TAG_MAX_RESULTS) : st;
  endfunction

endpackage

// File: rtl/pu_tag_result_collect_if.sv
// Bus bundle between the tag lookup stage, PU scheduler, PUs and the result collector.
interface pu_tag_result_collect_if
  import pu_tag_pkg::*;
#(
  parameter int unsigned PU_ID_NBITS   = TAG_PID_NBITS,
  parameter int unsigned RCI_NBITS     = TAG_RCI_NBITS,
  parameter int unsigned RES_IDX_NBITS = 3
);

  logic                     tag_lookup_valid;
  logic [RCI_NBITS-1:0]     tag_lookup_result;
  logic [PU_ID_NBITS-1:0]   tag_lookup_result_pid;
  logic [RES_IDX_NBITS-1:0] tag_lookup_result_num;
  logic                     tag_lookup_status_valid;
  logic [3:0]               tag_lookup_status;
  logic [PU_ID_NBITS-1:0]   tag_lookup_status_pid;

  logic                     done_valid;
  logic [PU_ID_NBITS-1:0]   done_pid;
  logic [3:0]               done_count;
  logic                     done_ready;

  logic                     pu_rd;
  logic [PU_ID_NBITS-1:0]   pu_rd_pid;
  logic [RES_IDX_NBITS-1:0] pu_rd_idx;
  logic                     pu_rd_valid;
  logic                     pu_rd_hit;
  logic [RCI_NBITS-1:0]     pu_rd_data;

  logic                     pu_release;
  logic [PU_ID_NBITS-1:0]   pu_release_pid;

  logic                     err_overflow;
  logic                     err_sticky;

  modport master (
    output tag_lookup_valid, tag_lookup_result, tag_lookup_result_pid, tag_lookup_result_num,
    output tag_lookup_status_valid, tag_lookup_status, tag_lookup_status_pid,
    input  done_valid, done_pid, done_count,
    output done_ready,
    output pu_rd, pu_rd_pid, pu_rd_idx,
    input  pu_rd_valid, pu_rd_hit, pu_rd_data,
    output pu_release, pu_release_pid,
    input  err_overflow, err_sticky
  );

  modport slave (
    input  tag_lookup_valid, tag_lookup_result, tag_lookup_result_pid, tag_lookup_result_num,
    input  tag_lookup_status_valid, tag_lookup_status, tag_lookup_status_pid,
    output done_valid, done_pid, done_count,
    input  done_ready,
    input  pu_rd, pu_rd_pid, pu_rd_idx,
    output pu_rd_valid, pu_rd_hit, pu_rd_data,
    input  pu_release, pu_release_pid,
    output err_overflow, err_sticky
  );

endinterface

// File: rtl/sfifo2f_fo.sv
// Synchronous first-word-fall-through FIFO; dout is the head entry whenever !empty.
module sfifo2f_fo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH_NBITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_NBITS;

  logic [DEPTH_NBITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_NBITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_NBITS:0]   count_q, count_d;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic                   full;
  logic                   do_push;
  logic                   do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (DEPTH_NBITS+1)'(DEPTH));
  assign dout  = mem[rd_ptr_q];

  // A push into a full queue is still legal when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/pu_tag_result_collect.sv
// Collects per-PU tag lookup payloads and status, announces completions and serves result reads.
module pu_tag_result_collect
  import pu_tag_pkg::*;
#(
  parameter int unsigned PU_ID_NBITS           = TAG_PID_NBITS,
  parameter int unsigned RCI_NBITS             = TAG_RCI_NBITS,
  parameter int unsigned RES_IDX_NBITS         = 3,
  parameter int unsigned DONE_FIFO_DEPTH_NBITS = PU_ID_NBITS
) (
  input logic                    clk,
  input logic                    rst,
  pu_tag_result_collect_if.slave bus
);

  localparam int unsigned NUM_PU    = 1 << PU_ID_NBITS;
  localparam int unsigned RAM_AW    = PU_ID_NBITS + RES_IDX_NBITS;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam int unsigned ENTRY_W   = PU_ID_NBITS + 4;

  localparam logic SLOT_IDLE = 1'b0;
  localparam logic SLOT_DONE = 1'b1;

  logic [NUM_PU-1:0]         done_q, done_d;
  logic [NUM_PU-1:0][3:0]    cnt_q, cnt_d;
  logic [RCI_NBITS-1:0]      result_ram [RAM_DEPTH];

  logic                      err_overflow_q, err_overflow_d;
  logic                      err_sticky_q, err_sticky_d;
  logic                      pu_rd_valid_q, pu_rd_valid_d;
  logic                      pu_rd_hit_q, pu_rd_hit_d;
  logic [RCI_NBITS-1:0]      pu_rd_data_q, pu_rd_data_d;

  logic                      pay_busy;
  logic                      stat_busy;
  logic                      ram_we;
  logic [RAM_AW-1:0]         ram_waddr;
  logic [RAM_AW-1:0]         ram_raddr;
  logic                      fifo_push;
  logic                      fifo_empty;
  logic [ENTRY_W-1:0]        fifo_dout;
  tag_done_entry_t           push_entry;
  tag_done_entry_t           head_entry;

  // A release in the same cycle frees the slot before payload/status are judged.
  assign pay_busy  = (done_q[bus.tag_lookup_result_pid] == SLOT_DONE) &&
                     !(bus.pu_release && (bus.pu_release_pid == bus.tag_lookup_result_pid));
  assign stat_busy = (done_q[bus.tag_lookup_status_pid] == SLOT_DONE) &&
                     !(bus.pu_release && (bus.pu_release_pid == bus.tag_lookup_status_pid));
  assign ram_waddr = {bus.tag_lookup_result_pid, bus.tag_lookup_result_num};
  assign ram_raddr = {bus.pu_rd_pid, bus.pu_rd_idx};

  always_comb begin
    done_d         = done_q;
    cnt_d          = cnt_q;
    ram_we         = 1'b0;
    fifo_push      = 1'b0;
    err_overflow_d = 1'b0;
    push_entry.pid   = TAG_PID_NBITS'(bus.tag_lookup_status_pid);
    push_entry.count = clamp_status(bus.tag_lookup_status);

    if (bus.pu_release) done_d[bus.pu_release_pid] = SLOT_IDLE;

    if (bus.tag_lookup_valid) begin
      if (pay_busy) err_overflow_d = 1'b1;
      else          ram_we         = 1'b1;
    end

    if (bus.tag_lookup_status_valid) begin
      if (stat_busy) begin
        err_overflow_d = 1'b1;
      end else begin
        done_d[bus.tag_lookup_status_pid] = SLOT_DONE;
        cnt_d[bus.tag_lookup_status_pid]  = push_entry.count;
        fifo_push                         = 1'b1;
      end
    end

    err_sticky_d = err_sticky_q | err_overflow_d;
  end

  // Reads observe the slot state as it was at the start of the cycle.
  always_comb begin
    pu_rd_valid_d = bus.pu_rd;
    pu_rd_hit_d   = bus.pu_rd && (done_q[bus.pu_rd_pid] == SLOT_DONE) &&
                    (4'(bus.pu_rd_idx) < cnt_q[bus.pu_rd_pid]);
    pu_rd_data_d  = pu_rd_hit_d ? result_ram[ram_raddr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q         <= '0;
      cnt_q          <= '0;
      err_overflow_q <= 1'b0;
      err_sticky_q   <= 1'b0;
      pu_rd_valid_q  <= 1'b0;
      pu_rd_hit_q    <= 1'b0;
      pu_rd_data_q   <= '0;
    end else begin
      done_q         <= done_d;
      cnt_q          <= cnt_d;
      err_overflow_q <= err_overflow_d;
      err_sticky_q   <= err_sticky_d;
      pu_rd_valid_q  <= pu_rd_valid_d;
      pu_rd_hit_q    <= pu_rd_hit_d;
      pu_rd_data_q   <= pu_rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) result_ram[ram_waddr] <= bus.tag_lookup_result;
  end

  sfifo2f_fo #(
    .WIDTH       (ENTRY_W),
    .DEPTH_NBITS (DONE_FIFO_DEPTH_NBITS)
  ) u_done_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (ENTRY_W'(push_entry)),
    .pop   (bus.done_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign head_entry       = tag_done_entry_t'(fifo_dout);
  assign bus.done_valid   = ~fifo_empty;
  assign bus.done_pid     = PU_ID_NBITS'(head_entry.pid);
  assign bus.done_count   = head_entry.count;
  assign bus.pu_rd_valid  = pu_rd_valid_q;
  assign bus.pu_rd_hit    = pu_rd_hit_q;
  assign bus.pu_rd_data   = pu_rd_data_q;
  assign bus.err_overflow = err_overflow_q;
  assign bus.err_sticky   = err_sticky_q;

endmodule

// File: tb/tb_pu_tag_result_collect.sv
// Scoreboard bench for pu_tag_result_collect: done queue and read responses checked against a slot model.
module tb_pu_tag_result_collect;

  typedef struct { logic [1:0] pid; logic [3:0] cnt; } done_exp_t;
  typedef struct { logic hit; logic [7:0] data; } rd_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pu_tag_result_collect_if #(.PU_ID_NBITS(2), .RCI_NBITS(8), .RES_IDX_NBITS(3)) bus ();

  pu_tag_result_collect #(
    .PU_ID_NBITS(2), .RCI_NBITS(8), .RES_IDX_NBITS(3), .DONE_FIFO_DEPTH_NBITS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  bit   [3:0] m_done;
  logic [3:0] m_cnt [4];
  logic [7:0] m_ram [32];
  bit         exp_err;
  done_exp_t  done_sb[$];
  rd_exp_t    rd_sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.tag_lookup_valid        = 1'b0;
    bus.tag_lookup_result       = '0;
    bus.tag_lookup_result_pid   = '0;
    bus.tag_lookup_result_num   = '0;
    bus.tag_lookup_status_valid = 1'b0;
    bus.tag_lookup_status       = '0;
    bus.tag_lookup_status_pid   = '0;
    bus.done_ready              = 1'b0;
    bus.pu_rd                   = 1'b0;
    bus.pu_rd_pid               = '0;
    bus.pu_rd_idx               = '0;
    bus.pu_release              = 1'b0;
    bus.pu_release_pid          = '0;
  endtask

  task automatic model_reset();
    m_done = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 4'd0;
    done_sb.delete();
    rd_sb.delete();
  endtask

  // One cycle of stimulus; expectations are pushed to the scoreboards as it is driven.
  task automatic drive(input logic pv, input logic [1:0] ppid, input logic [2:0] pnum,
                       input logic [7:0] pdat, input logic sv, input logic [1:0] spid,
                       input logic [3:0] st, input logic rel, input logic [1:0] rpid,
                       input logic rd, input logic [1:0] rdpid, input logic [2:0] rdidx,
                       input logic pop);
    bit pbusy, sbusy;
    rd_exp_t re;
    done_exp_t de;
    pbusy   = m_done[ppid] && !(rel && rpid == ppid);
    sbusy   = m_done[spid] && !(rel && rpid == spid);
    exp_err = (pv && pbusy) || (sv && sbusy);
    if (rd) begin
      re.hit  = m_done[rdpid] && ({1'b0, rdidx} < m_cnt[rdpid]);
      re.data = re.hit ? m_ram[{rdpid, rdidx}] : 8'h00;
      rd_sb.push_back(re);
    end
    if (rel) m_done[rpid] = 1'b0;
    if (pv && !pbusy) m_ram[{ppid, pnum}] = pdat;
    if (sv && !sbusy) begin
      m_done[spid] = 1'b1;
      m_cnt[spid]  = (st > 4'd8) ? 4'd8 : st;
      de.pid = spid;
      de.cnt = m_cnt[spid];
      done_sb.push_back(de);
    end
    bus.tag_lookup_valid        = pv;
    bus.tag_lookup_result_pid   = ppid;
    bus.tag_lookup_result_num   = pnum;
    bus.tag_lookup_result       = pdat;
    bus.tag_lookup_status_valid = sv;
    bus.tag_lookup_status_pid   = spid;
    bus.tag_lookup_status       = st;
    bus.pu_release              = rel;
    bus.pu_release_pid          = rpid;
    bus.pu_rd                   = rd;
    bus.pu_rd_pid               = rdpid;
    bus.pu_rd_idx               = rdidx;
    bus.done_ready              = pop;
    tick();
    clear_inputs();
  endtask

  task automatic payload(input logic [1:0] pid, input logic [2:0] num, input logic [7:0] d);
    drive(1'b1, pid, num, d, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0);
  endtask

  task automatic status(input logic [1:0] pid, input logic [3:0] st);
    drive(1'b0, 2'd0, 3'd0, 8'h00, 1'b1, pid, st, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0);
  endtask

  task automatic release_pid(input logic [1:0] pid);
    drive(1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b1, pid, 1'b0, 2'd0, 3'd0, 1'b0);
  endtask

  task automatic read(input logic [1:0] pid, input logic [2:0] idx);
    drive(1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, pid, idx, 1'b0);
  endtask

  task automatic pop_head();
    drive(1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (3) tick();
    total++; if (bus.done_valid !== 1'b0) begin bad++; $display("FAIL reset_done_valid got=%b exp=0", bus.done_valid); end
    total++; if (bus.pu_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", bus.pu_rd_valid); end
    total++; if (bus.pu_rd_hit !== 1'b0) begin bad++; $display("FAIL reset_rd_hit got=%b exp=0", bus.pu_rd_hit); end
    total++; if (bus.pu_rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", bus.pu_rd_data); end
    total++; if (bus.err_overflow !== 1'b0) begin bad++; $display("FAIL reset_err_overflow got=%b exp=0", bus.err_overflow); end
    total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err_sticky got=%b exp=0", bus.err_sticky); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    done_exp_t de;
    rd_exp_t re;
    payload(2'd2, 3'd0, 8'h11);
    payload(2'd2, 3'd1, 8'h22);
    payload(2'd2, 3'd2, 8'h33);
    status(2'd2, 4'd3);
    total++; if (bus.err_overflow !== exp_err) begin bad++; $display("FAIL basic_err got=%b exp=%b", bus.err_overflow, exp_err); end
    de = done_sb.pop_front();
    total++;
    if ({bus.done_valid, bus.done_pid, bus.done_count} !== {1'b1, de.pid, de.cnt}) begin
      bad++; $display("FAIL basic_done got v=%b pid=%0d cnt=%0d exp pid=%0d cnt=%0d", bus.done_valid, bus.done_pid, bus.done_count, de.pid, de.cnt);
    end
    pop_head();
    for (int i = 0; i < 4; i++) begin
      read(2'd2, 3'(i));
      re = rd_sb.pop_front();
      total++;
      if ({bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data} !== {1'b1, re.hit, re.data}) begin
        bad++; $display("FAIL basic_rd idx=%0d got v=%b h=%b d=%h exp h=%b d=%h", i, bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data, re.hit, re.data);
      end
    end
  endtask

  task automatic test_miss();
    done_exp_t de;
    rd_exp_t re;
    status(2'd1, 4'd0);
    de = done_sb.pop_front();
    total++;
    if ({bus.done_valid, bus.done_pid, bus.done_count} !== {1'b1, de.pid, de.cnt}) begin
      bad++; $display("FAIL miss_done got v=%b pid=%0d cnt=%0d exp pid=%0d cnt=%0d", bus.done_valid, bus.done_pid, bus.done_count, de.pid, de.cnt);
    end
    pop_head();
    read(2'd1, 3'd0);
    re = rd_sb.pop_front();
    total++;
    if ({bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data} !== {1'b1, re.hit, re.data}) begin
      bad++; $display("FAIL miss_rd got v=%b h=%b d=%h exp h=%b d=%h", bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data, re.hit, re.data);
    end
  endtask

  task automatic test_overflow();
    rd_exp_t re;
    status(2'd1, 4'd6);
    total++; if (bus.err_overflow !== exp_err || exp_err !== 1'b1) begin bad++; $display("FAIL ovf_status_err got=%b exp=%b", bus.err_overflow, exp_err); end
    total++; if (bus.err_sticky !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.err_sticky); end
    total++; if (bus.done_valid !== (done_sb.size() != 0)) begin bad++; $display("FAIL ovf_queue got=%b exp=%b", bus.done_valid, done_sb.size() != 0); end
    tick();
    total++; if (bus.err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_pulse got=%b exp=0", bus.err_overflow); end
    payload(2'd2, 3'd0, 8'hEE);
    total++; if (bus.err_overflow !== exp_err) begin bad++; $display("FAIL ovf_payload_err got=%b exp=%b", bus.err_overflow, exp_err); end
    read(2'd1, 3'd3);
    read(2'd2, 3'd0);
    for (int i = 0; i < 2; i++) begin
      re = rd_sb.pop_front();
      if (i == 1) begin
        total++;
        if ({bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data} !== {1'b1, re.hit, re.data}) begin
          bad++; $display("FAIL ovf_rd got v=%b h=%b d=%h exp h=%b d=%h", bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data, re.hit, re.data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] st_v [4];
    logic [1:0] rp [4];
    logic [2:0] ri [4];
    done_exp_t de;
    rd_exp_t re;
    st_v = '{4'd1, 4'd2, 4'd9, 4'd4};
    rp   = '{2'd0, 2'd2, 2'd3, 2'd1};
    ri   = '{3'd0, 3'd7, 3'd4, 3'd2};
    for (int k = 0; k < 4; k++) release_pid(2'(k));
    payload(2'd2, 3'd7, 8'h77);
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 2'd0, 3'd0, 8'hA0, 1'b1, 2'(k), st_v[k], 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0);
      total++; if (bus.err_overflow !== exp_err) begin bad++; $display("FAIL b2b_err k=%0d got=%b exp=%b", k, bus.err_overflow, exp_err); end
    end
    for (int k = 0; k < 4; k++) begin
      de = done_sb.pop_front();
      total++;
      if ({bus.done_valid, bus.done_pid, bus.done_count} !== {1'b1, de.pid, de.cnt}) begin
        bad++; $display("FAIL b2b_done k=%0d got v=%b pid=%0d cnt=%0d exp pid=%0d cnt=%0d", k, bus.done_valid, bus.done_pid, bus.done_count, de.pid, de.cnt);
      end
      pop_head();
    end
    total++; if (bus.done_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", bus.done_valid); end
    for (int k = 0; k < 4; k++) begin
      read(rp[k], ri[k]);
      re = rd_sb.pop_front();
      total++;
      if ({bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data} !== {1'b1, re.hit, re.data}) begin
        bad++; $display("FAIL b2b_rd pid=%0d idx=%0d got v=%b h=%b d=%h exp h=%b d=%h", rp[k], ri[k], bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data, re.hit, re.data);
      end
    end
  endtask

  task automatic test_release_race();
    done_exp_t de;
    rd_exp_t re;
    drive(1'b1, 2'd3, 3'd4, 8'h5A, 1'b1, 2'd3, 4'd5, 1'b1, 2'd3, 1'b0, 2'd0, 3'd0, 1'b0);
    total++; if (bus.err_overflow !== 1'b0) begin bad++; $display("FAIL race_err got=%b exp=0", bus.err_overflow); end
    de = done_sb.pop_front();
    total++;
    if ({bus.done_valid, bus.done_pid, bus.done_count} !== {1'b1, de.pid, de.cnt}) begin
      bad++; $display("FAIL race_done got v=%b pid=%0d cnt=%0d exp pid=%0d cnt=%0d", bus.done_valid, bus.done_pid, bus.done_count, de.pid, de.cnt);
    end
    pop_head();
    read(2'd3, 3'd4);
    drive(1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b1, 2'd0, 1'b1, 2'd0, 3'd0, 1'b0);
    read(2'd0, 3'd0);
    // Responses land one cycle apart; only the last one is still on the bus.
    for (int k = 0; k < 3; k++) begin
      re = rd_sb.pop_front();
      if (k == 2) begin
        total++;
        if ({bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data} !== {1'b1, re.hit, re.data}) begin
          bad++; $display("FAIL race_rd_after_release got v=%b h=%b d=%h exp h=%b d=%h", bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data, re.hit, re.data);
        end
      end
    end
    read(2'd3, 3'd4);
    drive(1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b1, 2'd3, 1'b1, 2'd3, 3'd4, 1'b0);
    re = rd_sb.pop_back();
    total++;
    if ({bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data} !== {1'b1, re.hit, re.data}) begin
      bad++; $display("FAIL race_rd_with_release got v=%b h=%b d=%h exp h=%b d=%h", bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data, re.hit, re.data);
    end
    re = rd_sb.pop_front();
  endtask

  task automatic test_reset_mid_read();
    rd_exp_t re;
    drive(1'b0, 2'd0, 3'd0, 8'h00, 1'b1, 2'd1, 4'd2, 1'b1, 2'd1, 1'b0, 2'd0, 3'd0, 1'b0);
    total++; if (bus.done_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_done got=%b exp=1", bus.done_valid); end
    rst           = 1'b1;
    bus.pu_rd     = 1'b1;
    bus.pu_rd_pid = 2'd1;
    bus.pu_rd_idx = 3'd0;
    tick();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    total++; if (bus.pu_rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_rd_valid got=%b exp=0", bus.pu_rd_valid); end
    total++; if (bus.done_valid !== 1'b0) begin bad++; $display("FAIL rstmid_done_valid got=%b exp=0", bus.done_valid); end
    total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL rstmid_sticky got=%b exp=0", bus.err_sticky); end
    read(2'd2, 3'd0);
    re = rd_sb.pop_front();
    total++;
    if ({bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data} !== {1'b1, re.hit, re.data}) begin
      bad++; $display("FAIL rstmid_rd got v=%b h=%b d=%h exp h=%b d=%h", bus.pu_rd_valid, bus.pu_rd_hit, bus.pu_rd_data, re.hit, re.data);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_miss();
    test_overflow();
    test_back_to_back();
    test_release_race();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
